// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_wb_ctrl_pkg: shared widths and the write-port source select encoding
package regfile_wb_ctrl_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_MEM
    } wb_sel_e;

endpackage

// File: rtl/regfile_wb_ctrl_pend_fifo.sv
// regfile_wb_ctrl_pend_fifo: circular buffer of pending load writes with per-entry valid
//   push/push_valid/push_addr/push_data : enqueue at write pointer
//   pop                                 : drop head (head_* show the entry being dropped)
//   kill/kill_addr                      : invalidate every stored entry aimed at kill_addr
//   s1_addr/s2_addr -> s1_hit/s2_hit    : any valid entry aimed at the address
//   count                               : occupied entries, valid or not
module regfile_wb_ctrl_pend_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_valid,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] s1_addr,
    input  logic [AW-1:0] s2_addr,
    output logic          s1_hit,
    output logic          s2_hit,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] vld_q, vld_d, m1, m2;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = vld_q[i] && addr_q[i] == s1_addr;
            m2[i] = vld_q[i] && addr_q[i] == s2_addr;
            if (kill && addr_q[i] == kill_addr) vld_d[i] = 1'b0;
        end
        // popped slots are cleared so vld alone means "occupied and still live"
        if (pop) begin
            vld_d[rd_q] = 1'b0;
            rd_d        = rd_q + PW'(1);
        end
        if (push) begin
            vld_d[wr_q]  = push_valid;
            addr_d[wr_q] = push_addr;
            data_d[wr_q] = push_data;
            wr_d         = wr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign s1_hit     = |m1;
    assign s2_hit     = |m2;
    assign head_valid = vld_q[rd_q];
    assign head_addr  = addr_q[rd_q];
    assign head_data  = data_q[rd_q];
    assign count      = cnt_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU and load results onto the single regfile write port
//   alu_*                  : ALU result, always wins the port, no backpressure
//   mem_valid/mem_ready    : load results buffered in a DEPTH-entry FIFO, drained when ALU idle
//   we/waddr/wdata         : registered regfile write port
//   raddrX -> fwdX_*/pendX : forward from write-port stage, stall on pending FIFO writes
//   fifo_count             : occupied FIFO entries
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_waddr,
    input  logic [DW-1:0] alu_wdata,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd2_data,
    output logic          pend1,
    output logic          pend2,
    output logic [CW-1:0] fifo_count
);

    wb_sel_e       sel;
    logic          alu_fire, push, push_valid, pop;
    logic          head_valid, s1_hit, s2_hit;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    always_comb begin
        alu_fire   = alu_valid && alu_waddr != '0;
        // ready looks only at the registered count so a same-cycle pop never admits a push
        mem_ready  = !rst && fifo_count < CW'(DEPTH);
        push       = mem_valid && mem_ready;
        // ALU is younger than a same-cycle load to the same register, so that load must not land
        push_valid = mem_waddr != '0 && !(alu_fire && mem_waddr == alu_waddr);
        sel        = alu_fire ? SEL_ALU : (fifo_count != '0 ? SEL_MEM : SEL_NONE);
        pop        = sel == SEL_MEM;
        we_d       = sel == SEL_ALU || (pop && head_valid);
        waddr_d    = sel == SEL_ALU ? alu_waddr : (pop ? head_addr : waddr_q);
        wdata_d    = sel == SEL_ALU ? alu_wdata : (pop ? head_data : wdata_q);
        pend1      = raddr1 != '0 && s1_hit;
        pend2      = raddr2 != '0 && s2_hit;
        fwd1_hit   = raddr1 != '0 && we_q && waddr_q == raddr1;
        fwd2_hit   = raddr2 != '0 && we_q && waddr_q == raddr2;
        fwd1_data  = raddr1 != '0 ? wdata_q : '0;
        fwd2_data  = raddr2 != '0 ? wdata_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    regfile_wb_ctrl_pend_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_valid (push_valid),
        .push_addr  (mem_waddr),
        .push_data  (mem_wdata),
        .pop        (pop),
        .kill       (alu_fire),
        .kill_addr  (alu_waddr),
        .s1_addr    (raddr1),
        .s2_addr    (raddr2),
        .s1_hit     (s1_hit),
        .s2_hit     (s2_hit),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (fifo_count)
    );

endmodule
